// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel tick, x/y counters, syncs, strobes.
// Optional frame counter built when VGA_TIMING_FRAME_CNT_EN is defined.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CNT_W     = 10,
  parameter int FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  output logic               p_tick,
  output logic [CNT_W-1:0]   x,
  output logic [CNT_W-1:0]   y,
  output logic               hsync,
  output logic               vsync,
  output logic               video_on,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_DISP   = CNT_W'(H_DISPLAY);
  localparam logic [CNT_W-1:0] V_DISP   = CNT_W'(V_DISPLAY);
  localparam logic [CNT_W-1:0] HS_LO    = CNT_W'(H_DISPLAY + H_FRONT);
  localparam logic [CNT_W-1:0] HS_HI    = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [CNT_W-1:0] VS_LO    = CNT_W'(V_DISPLAY + V_FRONT);
  localparam logic [CNT_W-1:0] VS_HI    = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] x_q, x_d;
  logic [CNT_W-1:0] y_q, y_d;
  logic             p_tick_q, p_tick_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             video_on_q, video_on_d;
  logic             line_start_q, line_start_d;
  logic             frame_start_q, frame_start_d;
  logic             frame_wrap;

  always_comb begin
    div_d         = div_q;
    x_d           = x_q;
    y_d           = y_q;
    p_tick_d      = 1'b0;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;
    frame_wrap    = 1'b0;
    if (en) begin
      p_tick_d = (div_q == DIV_LAST);
      div_d    = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
      // the pixel shown during a tick cycle is retired on its closing edge
      if (p_tick_q) begin
        if (x_q == H_LAST) begin
          x_d = '0;
          if (y_q == V_LAST) begin
            y_d        = '0;
            frame_wrap = 1'b1;
          end else begin
            y_d = y_q + 1'b1;
          end
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      line_start_d  = p_tick_d && (x_d == '0);
      frame_start_d = line_start_d && (y_d == '0);
    end
    hsync_d = ((x_d >= HS_LO) && (x_d <= HS_HI)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d = ((y_d >= VS_LO) && (y_d <= VS_HI)) ? VSYNC_POL : ~VSYNC_POL;
    video_on_d = (x_d < H_DISP) && (y_d < V_DISP);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_q         <= '0;
      x_q           <= '0;
      y_q           <= '0;
      p_tick_q      <= 1'b0;
      hsync_q       <= ~HSYNC_POL;
      vsync_q       <= ~VSYNC_POL;
      video_on_q    <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      x_q           <= x_d;
      y_q           <= y_d;
      p_tick_q      <= p_tick_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      video_on_q    <= video_on_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

`ifdef VGA_TIMING_FRAME_CNT_EN
  logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_wrap) frame_cnt_d = frame_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) frame_cnt_q <= '0;
    else       frame_cnt_q <= frame_cnt_d;
  end

  assign frame_cnt = frame_cnt_q;
`else
  logic unused_wrap;
  assign unused_wrap = frame_wrap;
  assign frame_cnt   = '0;
`endif

  assign p_tick      = p_tick_q;
  assign x           = x_q;
  assign y           = y_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised raster timing generator for the VGA display path: divides the system clock into a pixel tick and produces horizontal and vertical counters, programmable-polarity sync, display-enable, and line/frame start strobes. Timing geometry, clock divide ratio, and sync polarities are parameters, so one block serves 640x480 and any other mode. All outputs are registered and cycle-aligned with each other. It feeds pixel generators and the VGA pins, and adds a pause input and an optional frame counter.

## Interface
- CLK_DIV, 4, system clocks per pixel; must be ≥1.
- H_DISPLAY, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in pixels.
- H_SYNC, 96, horizontal sync width in pixels.
- H_BACK, 48, horizontal back porch in pixels.
- V_DISPLAY, 480, visible lines.
- V_FRONT, 10, vertical front porch in lines.
- V_SYNC, 2, vertical sync width in lines.
- V_BACK, 33, vertical back porch in lines.
- HSYNC_POL, 0, active level of hsync (0 = active-low).
- VSYNC_POL, 0, active level of vsync.
- CNT_W, 10, width of x/y; must hold H_TOTAL-1 and V_TOTAL-1.
- FRAME_W, 8, width of frame_cnt.

Ports:
- clk  in  1  system clock; one clock domain.
- reset  in  1  synchronous, active-high reset.
- en  in  1  run enable; low freezes all timing state.
- p_tick  out  1  pixel tick, one clk wide.
- x  out  CNT_W  horizontal position, 0..H_TOTAL-1.
- y  out  CNT_W  vertical position, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync, HSYNC_POL when active.
- vsync  out  1  vertical sync, VSYNC_POL when active.
- video_on  out  1  high when x<H_DISPLAY and y<V_DISPLAY.
- line_start  out  1  strobe on the p_tick cycle where x==0.
- frame_start  out  1  strobe on the p_tick cycle where x==0 and y==0.
- frame_cnt  out  FRAME_W  completed-frame count.

## Operation
- H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (default 800). V_TOTAL is the vertical equivalent (default 525).
- Divider div_cnt counts 0..CLK_DIV-1 and wraps; it advances only when en=1.
- p_tick is registered. It is high in the cycle after div_cnt==CLK_DIV-1 was sampled with en=1. For CLK_DIV=1, p_tick is high on every enabled cycle.
- The pixel at (x,y) is consumed in the cycle where p_tick=1. On that clk edge, x advances.
- x wraps H_TOTAL-1 → 0. y increments only on the x wrap, and y wraps V_TOTAL-1 → 0.
- Horizontal sync is active for x in [H_DISPLAY+H_FRONT, H_DISPLAY+H_FRONT+H_SYNC-1]. Vertical sync is active for y in the matching V window.
- hsync, vsync, and video_on are registered from next-state counters, so they change on the same edge as x/y.
- line_start and frame_start are also registered from next-state logic.
- When en=0:
  - div_cnt, x, y, syncs, video_on, and frame_cnt hold their values.
  - p_tick, line_start, and frame_start are 0.
  - When en returns to 1, counting resumes from the frozen div_cnt.
- Reset is synchronous and overrides en. Mid-frame reset returns all state to reset values on the next edge.

## Timing
- Reset values:
  - p_tick=0, x=0, y=0, video_on=1.
  - hsync=~HSYNC_POL, vsync=~VSYNC_POL.
  - line_start=0, frame_start=0, frame_cnt=0.
- With en=1 held from reset release, the first p_tick is at edge CLK_DIV after release. That cycle has x=0, y=0, line_start=1, frame_start=1.
- Output-to-tick latency is 0: strobes coincide with p_tick.
- Default mode timing:
  - Line period is 3200 clk; frame period is 1 680 000 clk.
  - hsync is active for x=656..751. vsync is active for y=490..491.

## Configuration
- VGA_TIMING_FRAME_CNT_EN defined:
  - frame_cnt increments on the edge where x wraps H_TOTAL-1→0 and y wraps V_TOTAL-1→0.
  - It wraps modulo 2^FRAME_W.
- Macro undefined: frame_cnt is tied to 0 and no counter logic is built. The port remains.

## Test plan
- Reset:
  - Stimulus: hold reset 3 cycles with en=1.
  - Response: x=0, y=0, hsync=1, vsync=1, video_on=1, p_tick=0. First p_tick 4 clk after release, with line_start=frame_start=1.
- Default horizontal:
  - Stimulus: run one line.
  - Response: p_tick every 4 clk. hsync low exactly for x=656..751. video_on falls at x=640. x wraps 799→0 and y goes 0→1 on the same edge.
- Default vertical:
  - Stimulus: run one full frame.
  - Response: vsync low for y=490..491. The next frame_start comes 1 680 000 clk after the first.
- Small mode:
  - Stimulus: CLK_DIV=1, H=4/1/2/1, V=3/1/1/1, HSYNC_POL=VSYNC_POL=1.
  - Response: p_tick constant 1. hsync high for x=5..6 each 8-clk line. vsync high for y=4. Frame period is 48 clk.
- Pause and reset:
  - Stimulus: drop en for 10 clk mid-line, then assert reset mid-frame.
  - Response: outputs frozen and strobes 0 during the pause. Timing resumes with the identical tick phase. Reset returns every output to its reset value on the next edge.
- Frame counter:
  - Stimulus: small mode, FRAME_W=2, macro defined, run 5 frames.
  - Response: frame_cnt steps 1,2,3,0,1 at the frame wrap edges. With the macro undefined, frame_cnt stays 0.
